// File: rtl/arbiter_pkg.sv
// Shared sizing, FSM state encoding and packet layout for the AER readout path.
package arbiter_pkg;
    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int POLARITY = 2;
    localparam int TS_W     = 16;
    localparam int x_width  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int y_width  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        SEND,
        SETTLE
    } aer_state_t;

    typedef struct packed {
        logic [x_width-1:0] x;
        logic [y_width-1:0] y;
        logic               pol;
        logic [TS_W-1:0]    ts;
    } aer_pkt_t;
endpackage

// File: rtl/aer_readout_ctrl_gnt_encoder.sv
// Grant matrix to row/column index: lowest row wins, then lowest column;
// flags any grant and more than one grant.
module gnt_encoder
    import arbiter_pkg::*;
#(
    parameter int ROWS = arbiter_pkg::ROWS,
    parameter int COLS = arbiter_pkg::COLS
) (
    input  logic [ROWS-1:0][COLS-1:0] i_gnt,
    output logic [x_width-1:0]        o_x,
    output logic [y_width-1:0]        o_y,
    output logic                      o_any,
    output logic                      o_multi
);
    always_comb begin
        o_x     = '0;
        o_y     = '0;
        o_any   = 1'b0;
        o_multi = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_gnt[r][c]) begin
                    if (o_any) begin
                        o_multi = 1'b1;
                    end else begin
                        o_x   = x_width'(r);
                        o_y   = y_width'(c);
                        o_any = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/aer_readout_ctrl.sv
// AER readout: latches pixel events, drives the 2-D arbiter and emits one packet per grant.
// Optional macro AER_TIMESTAMP_EN adds a free-running timestamp captured at the grant.
module aer_readout_ctrl
    import arbiter_pkg::*;
#(
    parameter int ROWS        = arbiter_pkg::ROWS,
    parameter int COLS        = arbiter_pkg::COLS,
    parameter int POLARITY    = arbiter_pkg::POLARITY,
    parameter int TS_W        = arbiter_pkg::TS_W,
    parameter int GNT_TIMEOUT = 15
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    enable_i,
    input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] evt_i,
    output logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] arb_req_o,
    output logic                                    arb_en_o,
    input  logic [ROWS-1:0][COLS-1:0]               arb_gnt_i,
    input  logic                                    arb_pol_i,
    output logic                                    pkt_valid_o,
    input  logic                                    pkt_ready_i,
    output logic [x_width-1:0]                      pkt_x_o,
    output logic [y_width-1:0]                      pkt_y_o,
    output logic                                    pkt_pol_o,
    output logic [TS_W-1:0]                         pkt_ts_o,
    output logic                                    drop_o,
    output logic                                    err_o
);
    localparam int WAIT_W   = $clog2(GNT_TIMEOUT + 1);
    localparam int PKT_TS_W = arbiter_pkg::TS_W;

    aer_state_t                              r_state, w_state_nxt;
    logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] r_pend, w_clr;
    aer_pkt_t                                r_pkt, w_pkt_nxt;
    logic [WAIT_W-1:0]                       r_wait;
    logic                                    r_err, r_drop, w_err_nxt, w_capture, w_hs;
    logic [x_width-1:0]                      w_x;
    logic [y_width-1:0]                      w_y;
    logic                                    w_any, w_multi;
    logic [TS_W-1:0]                         w_ts;

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_ts <= '0;
        else         r_ts <= r_ts + TS_W'(1);
    end
    assign w_ts = r_ts;
`else
    assign w_ts = '0;
`endif

    gnt_encoder #(.ROWS(ROWS), .COLS(COLS)) u_enc (
        .i_gnt   (arb_gnt_i),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    assign arb_en_o    = (r_state == WAIT_GNT);
    assign pkt_valid_o = (r_state == SEND);
    assign w_hs        = pkt_valid_o & pkt_ready_i;
    assign arb_req_o   = r_pend;
    assign pkt_x_o     = r_pkt.x;
    assign pkt_y_o     = r_pkt.y;
    assign pkt_pol_o   = r_pkt.pol;
    assign pkt_ts_o    = r_pkt.ts[TS_W-1:0];
    assign err_o       = r_err;
    assign drop_o      = r_drop;
    assign w_pkt_nxt   = '{x: w_x, y: w_y, pol: arb_pol_i, ts: PKT_TS_W'(w_ts)};

    // Clearing an already-clear bit on a stale grant is harmless by construction.
    always_comb begin
        w_clr = '0;
        if (w_hs) w_clr[r_pkt.x][r_pkt.y][r_pkt.pol] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            IDLE:     if (enable_i && (|r_pend)) w_state_nxt = WAIT_GNT;
            WAIT_GNT: begin
                if (!enable_i) begin
                    w_state_nxt = IDLE;
                end else if (w_any) begin
                    w_state_nxt = SEND;
                    w_capture   = 1'b1;
                    w_err_nxt   = w_multi;
                end else if (r_wait == WAIT_W'(GNT_TIMEOUT - 1)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            SEND:     if (pkt_ready_i) w_state_nxt = SETTLE;
            SETTLE:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // A new event on the same cycle as its own clear wins and is not a drop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_pkt   <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= (r_pend & ~w_clr) | evt_i;
            r_drop  <= |(evt_i & r_pend & ~w_clr);
            r_err   <= w_err_nxt;
            r_wait  <= (r_state == WAIT_GNT) ? r_wait + WAIT_W'(1) : '0;
            if (w_capture) r_pkt <= w_pkt_nxt;
        end
    end
endmodule

// File: tb/tb_aer_readout_ctrl.sv
// Directed bench for aer_readout_ctrl with a per-cycle pending/drop/packet model.
`timescale 1ns/1ps
module tb_aer_readout_ctrl;
    localparam int R = 8, C = 8, P = 2, TSW = 4;
`ifdef AER_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif
    typedef logic [R-1:0][C-1:0][P-1:0] pix_t;
    typedef logic [R-1:0][C-1:0]        gnt_t;
    typedef struct { int x; int y; int pol; int ts; } pkt_t;

    logic       clk_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0;
    logic       arb_pol_i = 1'b0, pkt_ready_i = 1'b0;
    pix_t       evt_i = '0;
    gnt_t       arb_gnt_i = '0;
    pix_t       arb_req_o;
    logic       arb_en_o, pkt_valid_o, pkt_pol_o, drop_o, err_o;
    logic [2:0] pkt_x_o, pkt_y_o;
    logic [TSW-1:0] pkt_ts_o;

    int   n_cmp = 0, n_mis = 0, n_hs = 0, n_drop = 0;
    pix_t m_pend = '0;
    logic m_drop = 1'b0, m_hs, m_clr, m_nd;
    int   m_ts = 0;
    pkt_t q[$];

    always #5 clk_i = ~clk_i;

    aer_readout_ctrl #(.ROWS(R), .COLS(C), .POLARITY(P), .TS_W(TSW), .GNT_TIMEOUT(15)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .evt_i(evt_i),
        .arb_req_o(arb_req_o), .arb_en_o(arb_en_o), .arb_gnt_i(arb_gnt_i),
        .arb_pol_i(arb_pol_i), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_x_o(pkt_x_o), .pkt_y_o(pkt_y_o), .pkt_pol_o(pkt_pol_o), .pkt_ts_o(pkt_ts_o),
        .drop_o(drop_o), .err_o(err_o)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Model: pending set/clear/drop rules, expected-packet queue, timestamp counter.
    always @(negedge clk_i) begin
        if (reset_i) begin
            m_pend = '0; m_drop = 1'b0; m_ts = 0; q.delete();
        end
        check("arb_req", arb_req_o, m_pend);
        check("drop", drop_o, m_drop);
        if (drop_o) n_drop++;
        if (pkt_valid_o) begin
            if (q.size() == 0) check("pkt_expected", pkt_valid_o, 0);
            else begin
                check("pkt_x", pkt_x_o, q[0].x);
                check("pkt_y", pkt_y_o, q[0].y);
                check("pkt_pol", pkt_pol_o, q[0].pol);
                check("pkt_ts", pkt_ts_o, q[0].ts);
            end
        end
        if (!reset_i) begin
            m_hs = pkt_valid_o && pkt_ready_i;
            m_nd = 1'b0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    for (int p = 0; p < P; p++) begin
                        m_clr = m_hs && q.size() > 0 && q[0].x == r && q[0].y == c && q[0].pol == p;
                        if (evt_i[r][c][p] && m_pend[r][c][p] && !m_clr) m_nd = 1'b1;
                        m_pend[r][c][p] = evt_i[r][c][p] || (m_pend[r][c][p] && !m_clr);
                    end
            m_drop = m_nd;
            if (m_hs) begin
                n_hs++;
                if (q.size() > 0) void'(q.pop_front());
            end
            m_ts = (m_ts + 1) % (1 << TSW);
        end
    end

    function automatic gnt_t one_hot(input int r, input int c);
        gnt_t g = '0;
        g[r][c] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic pulse_evt(input int r, input int c, input int p);
        evt_i[r][c][p] = 1'b1; tick(); evt_i = '0;
    endtask

    task automatic wait_en();
        for (int k = 0; k < 40 && !arb_en_o; k++) tick();
        check("arb_en_reached", arb_en_o, 1);
    endtask

    task automatic grant(input gnt_t g, input logic p);
        pkt_t e;
        e.x = -1; e.y = -1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (g[r][c] && e.x < 0) begin e.x = r; e.y = c; end
        e.pol = int'(p);
        e.ts  = TS_ON ? m_ts : 0;
        q.push_back(e);
        arb_gnt_i = g; arb_pol_i = p; tick(); arb_gnt_i = '0; arb_pol_i = 1'b0;
    endtask

    task automatic serve(input int r, input int c, input int p);
        pkt_ready_i = 1'b1; wait_en(); grant(one_hot(r, c), p[0]); tick(); tick();
    endtask

    task automatic ts_case(input int r, input int c, input int p, input int target);
        enable_i = 1'b0; pkt_ready_i = 1'b1;
        pulse_evt(r, c, p);
        for (int k = 0; k < 40 && m_ts != (target + 14) % 16; k++) tick();
        enable_i = 1'b1; wait_en();
        for (int k = 0; k < 4 && m_ts != target; k++) tick();
        grant(one_hot(r, c), p[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int hs0, d0;
        repeat (2) tick();
        check("rst_en", arb_en_o, 0);
        check("rst_valid", pkt_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_req", arb_req_o, 0);
        reset_i = 1'b0;

        // Single event, grant two cycles later, ready high.
        enable_i = 1'b1; pkt_ready_i = 1'b1;
        pulse_evt(2, 5, 1);
        check("single_pend", arb_req_o[2][5][1], 1);
        tick();
        check("single_en", arb_en_o, 1);
        grant(one_hot(2, 5), 1'b1);
        check("single_valid", pkt_valid_o, 1);
        check("single_x", pkt_x_o, 2);
        check("single_y", pkt_y_o, 5);
        check("single_pol", pkt_pol_o, 1);
        check("single_err", err_o, 0);
        tick();
        check("single_clear", arb_req_o, 0);
        check("single_settle_valid", pkt_valid_o, 0);
        check("single_settle_en", arb_en_o, 0);
        tick();

        // Backpressure for 10 cycles.
        pkt_ready_i = 1'b0; hs0 = n_hs;
        pulse_evt(4, 4, 0); wait_en(); grant(one_hot(4, 4), 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", pkt_valid_o, 1);
            check("bp_x", pkt_x_o, 4);
            check("bp_y", pkt_y_o, 4);
            check("bp_en_low", arb_en_o, 0);
            if (i < 9) tick();
        end
        pkt_ready_i = 1'b1; tick(); tick(); tick();
        check("bp_one_pkt", n_hs - hs0, 1);

        // Duplicate event while pending, then event on the handshake cycle.
        enable_i = 1'b0; d0 = n_drop;
        pulse_evt(0, 0, 0); pulse_evt(0, 0, 0);
        check("dup_drop", drop_o, 1);
        tick();
        check("dup_drop_once", n_drop - d0, 1);
        enable_i = 1'b1; wait_en(); grant(one_hot(0, 0), 1'b0);
        evt_i[0][0][0] = 1'b1; tick(); evt_i = '0;
        check("hs_set_wins", arb_req_o[0][0][0], 1);
        check("hs_no_drop", drop_o, 0);
        serve(0, 0, 0);

        // Grant timeout after 15 waiting cycles.
        pulse_evt(1, 1, 1); wait_en();
        for (int i = 0; i < 14; i++) tick();
        check("to_still_wait", arb_en_o, 1);
        check("to_no_err_yet", err_o, 0);
        tick();
        check("to_err", err_o, 1);
        check("to_idle", arb_en_o, 0);
        wait_en();
        check("to_err_pulse", err_o, 0);

        // Multi-hot grant on a stale bit: row 3 col 1 wins, err pulses, clear is a no-op.
        pkt_ready_i = 1'b0;
        grant(one_hot(3, 1) | one_hot(3, 6), 1'b0);
        check("multi_valid", pkt_valid_o, 1);
        check("multi_x", pkt_x_o, 3);
        check("multi_y", pkt_y_o, 1);
        check("multi_err", err_o, 1);
        pkt_ready_i = 1'b1; tick();
        check("stale_noop", arb_req_o[1][1][1], 1);
        check("multi_err_pulse", err_o, 0);
        serve(1, 1, 1);

        // Enable falling in WAIT_GNT aborts; falling in SEND completes.
        pulse_evt(5, 2, 0); wait_en(); enable_i = 1'b0; tick();
        check("en_wait_idle", arb_en_o, 0);
        check("en_wait_novalid", pkt_valid_o, 0);
        enable_i = 1'b1; pkt_ready_i = 1'b0; wait_en(); grant(one_hot(5, 2), 1'b0);
        enable_i = 1'b0; tick(); tick();
        check("en_send_valid", pkt_valid_o, 1);
        pkt_ready_i = 1'b1; tick();
        check("en_send_done", pkt_valid_o, 0);
        check("en_send_clear", arb_req_o, 0);
        tick();

        // Reset in the middle of SEND.
        enable_i = 1'b1; pkt_ready_i = 1'b0;
        pulse_evt(6, 7, 1); wait_en(); grant(one_hot(6, 7), 1'b1);
        check("mid_valid", pkt_valid_o, 1);
        reset_i = 1'b1; #1;
        check("mid_rst_valid", pkt_valid_o, 0);
        check("mid_rst_req", arb_req_o, 0);
        check("mid_rst_x", pkt_x_o, 0);
        check("mid_rst_y", pkt_y_o, 0);
        check("mid_rst_pol", pkt_pol_o, 0);
        check("mid_rst_en", arb_en_o, 0);
        tick();
        reset_i = 1'b0; enable_i = 1'b0;
        tick();

        // Timestamp captured at counter 15, then at the wrap to 0.
        ts_case(7, 0, 1, 15);
        check("ts_15", pkt_ts_o, TS_ON ? 15 : 0);
        enable_i = 1'b0; tick(); tick();
        ts_case(7, 0, 0, 0);
        check("ts_wrap_0", pkt_ts_o, 0);
        check("ts_wrap_x", pkt_x_o, 7);
        enable_i = 1'b0; tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
